// File: rtl/pss_pkg.sv
// rtl/pss_pkg.sv - shared constants and state type for the NR PSS generator and correlator
package pss_pkg;

  localparam int         PSS_LEN    = 127;
  localparam logic [6:0] LFSR_INIT  = 7'b1110110;
  localparam int         CELL_SHIFT = 43;
  localparam int         DC_OFFSET  = 63;

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    STREAM
  } pss_state_e;

  // LFSR steps needed so that the current bit is d(63), the DC subcarrier of bin 0
  function automatic logic [6:0] seek_len(input logic [1:0] n_id_2);
    return 7'((DC_OFFSET + CELL_SHIFT * int'(n_id_2)) % PSS_LEN);
  endfunction

endpackage

// File: rtl/pss_lfsr.sv
// rtl/pss_lfsr.sv - 7-bit m-sequence LFSR, x(i+7) = x(i+4) ^ x(i); s[0] is the current bit x(i)
module pss_lfsr
  import pss_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic step_i,
  output logic bit_o,
  output logic next_bit_o
);

  logic [6:0] s;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s <= LFSR_INIT;
    end else if (load_i) begin
      s <= LFSR_INIT;
    end else if (step_i) begin
      s <= {s[4] ^ s[0], s[6:1]};
    end
  end

  assign bit_o      = s[0];
  // bit that becomes current after one step, for callers that register ahead
  assign next_bit_o = s[1];

endmodule

// File: rtl/pss_freq_gen.sv
// rtl/pss_freq_gen.sv - frequency-domain NR PSS symbol source, one NFFT-bin symbol per start
module pss_freq_gen
  import pss_pkg::*;
#(
  parameter int NFFT   = 256,
  parameter int OUT_DW = 32,
  parameter int AMP    = 16384
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [1:0]        N_id_2_i,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready,
  output logic              m_axis_out_tlast,
  output logic              busy_o
);

  localparam int              BW       = $clog2(NFFT);
  localparam int              HW       = OUT_DW / 2;
  localparam logic [BW-1:0]   LAST_BIN = BW'(NFFT - 1);
  localparam logic [BW-1:0]   LO_END   = BW'(DC_OFFSET);
  localparam logic [BW-1:0]   HI_START = BW'(NFFT - DC_OFFSET);
  localparam logic [HW-1:0]   AMP_POS  = HW'(AMP);
  localparam logic [HW-1:0]   AMP_NEG  = HW'(-AMP);

  pss_state_e        state, state_nxt;
  logic [6:0]        seek_cnt;
  logic [BW-1:0]     bin_cnt, bin_nxt;
  logic              lfsr_load, lfsr_step, lfsr_bit, lfsr_next_bit;
  logic              handshake, next_bit_sel;
  logic [OUT_DW-1:0] next_word, first_word;

  function automatic logic is_data(input logic [BW-1:0] b);
    return (b <= LO_END) || (b >= HI_START);
  endfunction

  pss_lfsr u_lfsr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (lfsr_load),
    .step_i     (lfsr_step),
    .bit_o      (lfsr_bit),
    .next_bit_o (lfsr_next_bit)
  );

  assign handshake = m_axis_out_tvalid && m_axis_out_tready;
  assign busy_o    = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && (N_id_2_i != 2'd3)) begin
          state_nxt = SEEK;
          lfsr_load = 1'b1;
        end
      end
      SEEK: begin
        lfsr_step = 1'b1;
        if (seek_cnt == 7'd1) begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (handshake) begin
          lfsr_step = is_data(bin_cnt);
          if (bin_cnt == LAST_BIN) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The output register holds the bin on offer, so the next bin is built one step ahead:
  // if the current bin consumes a sequence element, the following one is s[1], else s[0].
  always_comb begin
    bin_nxt      = bin_cnt + BW'(1);
    next_bit_sel = is_data(bin_cnt) ? lfsr_next_bit : lfsr_bit;
    next_word    = '0;
    if (is_data(bin_nxt)) begin
      next_word = {{HW{1'b0}}, (next_bit_sel ? AMP_NEG : AMP_POS)};
    end
    first_word = {{HW{1'b0}}, (lfsr_next_bit ? AMP_NEG : AMP_POS)};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      seek_cnt          <= '0;
      bin_cnt           <= '0;
      m_axis_out_tvalid <= 1'b0;
      m_axis_out_tlast  <= 1'b0;
      m_axis_out_tdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lfsr_load) begin
            seek_cnt <= seek_len(N_id_2_i);
          end
        end
        SEEK: begin
          seek_cnt <= seek_cnt - 7'd1;
          if (seek_cnt == 7'd1) begin
            m_axis_out_tvalid <= 1'b1;
            m_axis_out_tdata  <= first_word;
            m_axis_out_tlast  <= 1'b0;
            bin_cnt           <= '0;
          end
        end
        STREAM: begin
          if (handshake) begin
            if (bin_cnt == LAST_BIN) begin
              m_axis_out_tvalid <= 1'b0;
              m_axis_out_tlast  <= 1'b0;
              m_axis_out_tdata  <= '0;
              bin_cnt           <= '0;
            end else begin
              bin_cnt          <= bin_nxt;
              m_axis_out_tdata <= next_word;
              m_axis_out_tlast <= (bin_nxt == LAST_BIN);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pss_freq_gen.sv
// tb/tb_pss_freq_gen.sv - directed self-checking bench for pss_freq_gen against a sequence model
module tb_pss_freq_gen;

  localparam int NFFT   = 256;
  localparam int OUT_DW = 32;
  localparam int AMP    = 16384;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              start_i;
  logic [1:0]        N_id_2_i;
  logic [OUT_DW-1:0] m_axis_out_tdata;
  logic              m_axis_out_tvalid;
  logic              m_axis_out_tready;
  logic              m_axis_out_tlast;
  logic              busy_o;

  int vectors     = 0;
  int miscompares = 0;
  bit xseq[127];
  logic [31:0] got[NFFT];

  always #5 clk_i = ~clk_i;

  pss_freq_gen #(
    .NFFT   (NFFT),
    .OUT_DW (OUT_DW),
    .AMP    (AMP)
  ) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .start_i           (start_i),
    .N_id_2_i          (N_id_2_i),
    .m_axis_out_tdata  (m_axis_out_tdata),
    .m_axis_out_tvalid (m_axis_out_tvalid),
    .m_axis_out_tready (m_axis_out_tready),
    .m_axis_out_tlast  (m_axis_out_tlast),
    .busy_o            (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int nid, input int b);
    int n;
    int m;
    if (b == 0) n = 63;
    else if (b <= 63) n = 63 + b;
    else if (b >= NFFT - 63) n = b - (NFFT - 63);
    else return 32'd0;
    m = (n + 43 * nid) % 127;
    return xseq[m] ? {16'd0, 16'hC000} : {16'd0, 16'h4000};
  endfunction

  // Starts at the current negedge; returns at the negedge where busy_o is checked low.
  task automatic run_symbol(input logic [1:0] nid, input int exp_lat, input bit rand_ready,
                            input bit stray, input int abort_at);
    int lat;
    int idx;
    int budget;
    int nlast;
    bit holding;
    logic [31:0] hold_d;
    logic hold_l;
    start_i = 1'b1;
    N_id_2_i = nid;
    m_axis_out_tready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk_i);
      start_i = 1'b0;
      lat++;
      if (lat == 1) check("busy_after_start", {31'd0, busy_o}, 32'd1);
    end while (!m_axis_out_tvalid && lat < 200);
    check($sformatf("latency_nid%0d", nid), lat, exp_lat);

    idx = 0;
    budget = 0;
    nlast = 0;
    holding = 1'b0;
    while (idx < NFFT && budget < 4000) begin
      if (budget > 0) @(negedge clk_i);
      budget++;
      start_i = 1'b0;
      if (holding) begin
        check("stall_tdata", m_axis_out_tdata, hold_d);
        check("stall_tlast", {31'd0, m_axis_out_tlast}, {31'd0, hold_l});
      end
      if (stray && budget == 40) begin
        start_i = 1'b1;
        N_id_2_i = 2'd2;
      end
      m_axis_out_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (abort_at >= 0 && idx == abort_at) begin
        reset_i = 1'b1;
        break;
      end
      check("tvalid_in_symbol", {31'd0, m_axis_out_tvalid}, 32'd1);
      if (m_axis_out_tready) begin
        got[idx] = m_axis_out_tdata;
        check($sformatf("bin%0d_data", idx), m_axis_out_tdata, exp_word(int'(nid), idx));
        check($sformatf("bin%0d_tlast", idx), {31'd0, m_axis_out_tlast}, {31'd0, idx == NFFT - 1});
        if (m_axis_out_tlast) nlast++;
        idx++;
        holding = 1'b0;
      end else begin
        holding = 1'b1;
        hold_d = m_axis_out_tdata;
        hold_l = m_axis_out_tlast;
      end
    end

    if (abort_at >= 0) begin
      @(negedge clk_i);
      check("abort_tvalid", {31'd0, m_axis_out_tvalid}, 32'd0);
      check("abort_busy", {31'd0, busy_o}, 32'd0);
      check("abort_tlast", {31'd0, m_axis_out_tlast}, 32'd0);
      reset_i = 1'b0;
    end else begin
      check("bins_received", idx, NFFT);
      m_axis_out_tready = 1'b1;
      @(negedge clk_i);
      check("end_tvalid", {31'd0, m_axis_out_tvalid}, 32'd0);
      check("end_busy", {31'd0, busy_o}, 32'd0);
      check("tlast_count", nlast, 1);
    end
  endtask

  initial begin
    xseq[0] = 1'b0; xseq[1] = 1'b1; xseq[2] = 1'b1; xseq[3] = 1'b0;
    xseq[4] = 1'b1; xseq[5] = 1'b1; xseq[6] = 1'b1;
    for (int i = 0; i < 120; i++) xseq[i + 7] = xseq[i + 4] ^ xseq[i];

    reset_i = 1'b1;
    start_i = 1'b0;
    N_id_2_i = 2'd0;
    m_axis_out_tready = 1'b1;
    repeat (3) @(negedge clk_i);
    check("reset_tvalid", {31'd0, m_axis_out_tvalid}, 32'd0);
    check("reset_tlast", {31'd0, m_axis_out_tlast}, 32'd0);
    check("reset_tdata", m_axis_out_tdata, 32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i);

    run_symbol(2'd0, 64, 1'b0, 1'b0, -1);
    check("nid0_bin193", got[193], 32'h0000_4000);
    check("nid0_bin194", got[194], 32'h0000_C000);
    check("nid0_bin64", got[64], 32'h0000_0000);
    check("nid0_bin192", got[192], 32'h0000_0000);

    // back-to-back: each call starts on the cycle busy_o is first low
    run_symbol(2'd1, 107, 1'b0, 1'b0, -1);
    run_symbol(2'd2, 23, 1'b0, 1'b0, -1);
    run_symbol(2'd2, 23, 1'b0, 1'b0, -1);

    run_symbol(2'd0, 64, 1'b1, 1'b1, -1);

    start_i = 1'b1;
    N_id_2_i = 2'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("nid3_busy", {31'd0, busy_o}, 32'd0);
      check("nid3_tvalid", {31'd0, m_axis_out_tvalid}, 32'd0);
      @(negedge clk_i);
    end

    run_symbol(2'd1, 107, 1'b0, 1'b0, 100);
    run_symbol(2'd1, 107, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
